elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Latches floor call buttons and decides which floor the car serves next, using collective (SCAN) ordering.
- Drives the target-floor input of the elevator movement state machine and sequences a timed door-open phase at each stop.
- Sits between the top-level ui_in call buttons and the elevator movement state machine. current_floor feeds back from the movement block.

Parameters:
- NUM_FLOORS, 10, number of floors served (floors 0..NUM_FLOORS-1), max 16.
- FLOOR_W, 4, width of floor-number buses.
- DOOR_CYCLES, 16, clock cycles the door stays open per stop (>=2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- call_req  input  NUM_FLOORS  level/pulse call buttons, bit i = call to floor i, sampled every rising edge
- current_floor  input  FLOOR_W  floor reported by the movement block
- car_idle  input  1  movement block not moving (its IDLE state)
- target_floor  output  FLOOR_W  floor the movement block must travel to
- target_valid  output  1  target_floor is meaningful; movement block holds position when 0
- door_open  output  1  door-open indication
- dir_up  output  1  current sweep direction, 1 = up
- pending  output  NUM_FLOORS  latched outstanding calls

Behaviour:
- All outputs are registered.
- Reset values: pending=0, target_floor=0, target_valid=0, door_open=0, dir_up=1, state=IDLE, door counter=0.
- Request latching:
  - pending[i] sets on any edge where call_req[i]=1.
  - pending[i] clears only on entry to DOOR at floor i.
  - Set and clear on the same edge for the same floor: clear wins.
  - call_req for the current floor while in DOOR is absorbed: the bit is not set and the door counter restarts at 0.
- Definitions: above = any pending[j] with j > current_floor; below = any pending[j] with j < current_floor.
- Target selection: target is the nearest pending floor in the sweep direction, recomputed every cycle while in SERVE_UP or SERVE_DOWN. A nearer new call in the same direction therefore retargets the car mid-travel.
- States: IDLE, SERVE_UP, SERVE_DOWN, DOOR.
- IDLE, checked in priority order:
  - pending[current_floor] and car_idle -> DOOR.
  - Else, if above or below, go toward the nearest pending floor; on a distance tie, go up. Move to SERVE_UP (dir_up=1) or SERVE_DOWN (dir_up=0).
  - Otherwise stay in IDLE with target_valid=0.
- SERVE_UP:
  - target_valid=1, target_floor = lowest pending j >= current_floor.
  - Arrival: car_idle=1, current_floor==target_floor and pending[target_floor]=1 -> DOOR.
  - If no pending j >= current_floor remains: go to SERVE_DOWN if below, else IDLE.
- SERVE_DOWN: mirror of SERVE_UP, using the highest pending j <= current_floor.
- DOOR:
  - On entry edge: door_open=1, target_valid=0, pending[current_floor] cleared, counter=0.
  - Counter increments each cycle. When counter==DOOR_CYCLES-1, door_open falls on the next edge.
  - Exit: continue in dir_up direction if calls remain that way, else reverse if calls exist, else IDLE.
- Latency:
  - Call pulse at edge N -> pending visible after N.
  - target_valid/target_floor/state update at edge N+1.
  - door_open rises at the edge after the arrival condition is first true.
- current_floor >= NUM_FLOORS (fault): go to IDLE, target_valid=0, pending retained. Resume normally once the value is back in range.
- Reset mid-operation: every register returns to its reset value immediately and asynchronously. All pending calls are lost.
- Calls are never dropped except by DOOR service or reset.

Test Plan:
- Reset, current_floor=0, car_idle=1, 1-cycle pulse call_req[3] -> pending=0x008 next cycle; target_valid=1, target_floor=3, dir_up=1 one cycle later; door_open=0.
- Car at floor 2, pending {5,7}, call_req[4] while travelling -> target_floor changes 5->4. Stops occur in order 4, 5, 7. door_open high exactly 16 cycles at each stop, with the matching pending bit cleared on each door-open rising edge.
- Car at floor 5, idle, calls {2,8} set on the same edge -> distance tie 3/3 -> SERVE_UP, target 8. After the door at 8 closes -> SERVE_DOWN, target 2, dir_up=0.
- In DOOR at floor 4, call_req[4] asserted at counter=10 -> pending[4] stays 0, counter restarts, door_open held 16 more cycles.
- Call at current floor 6 while IDLE and car_idle=1 -> DOOR next edge with no movement (target_valid stays 0). pending returns to 0 after entry.
- Pending {1,9}, assert reset mid-travel -> all outputs are at reset values asynchronously; after release, no target_valid without new calls. Also: current_floor=12 -> IDLE, target_valid=0, pending unchanged.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) elevator call scheduler: latches floor calls,
// picks the next stop and times the door-open phase.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_W     = 4,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_W =
    (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_UP,
    SERVE_DOWN,
    DOOR
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic                  in_range;
  int                    cur;
  logic [NUM_FLOORS-1:0] cur_hot;
  logic [NUM_FLOORS-1:0] tgt_hot;
  logic                  here;
  logic                  call_here;
  logic                  arrive;

  logic               up_found, dn_found;
  logic [FLOOR_W-1:0] up_floor, dn_floor;
  logic               above, below;
  logic [FLOOR_W-1:0] ab_floor, bl_floor;
  logic [FLOOR_W-1:0] dist_up, dist_dn;
  logic               go_up;

  logic                  entry;
  logic [NUM_FLOORS-1:0] absorb;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [FLOOR_W-1:0]    tf_n;
  logic                  tv_n;
  logic                  dir_n;

  assign in_range = 32'(current_floor) < NUM_FLOORS;
  assign cur      = 32'(current_floor);
  assign cur_hot  = in_range ?
    (NUM_FLOORS'(1) << current_floor) : '0;
  assign tgt_hot  = NUM_FLOORS'(1) << target_floor;

  assign here      = |(pending & cur_hot);
  assign call_here = |(call_req & cur_hot);
  assign arrive    = car_idle
                  && (current_floor == target_floor)
                  && |(pending & tgt_hot);

  // Nearest pending floor on each side of the car.
  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    above    = 1'b0;
    ab_floor = '0;
    for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
      if (pending[j] && j >= cur) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(j);
      end
      if (pending[j] && j > cur) begin
        above    = 1'b1;
        ab_floor = FLOOR_W'(j);
      end
    end
    dn_found = 1'b0;
    dn_floor = '0;
    below    = 1'b0;
    bl_floor = '0;
    for (int j = 0; j < NUM_FLOORS; j++) begin
      if (pending[j] && j <= cur) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(j);
      end
      if (pending[j] && j < cur) begin
        below    = 1'b1;
        bl_floor = FLOOR_W'(j);
      end
    end
  end

  assign dist_up = ab_floor - current_floor;
  assign dist_dn = current_floor - bl_floor;
  assign go_up   = above && (!below || dist_up <= dist_dn);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!in_range) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (here && car_idle)
            state_n = DOOR;
          else if (above || below)
            state_n = go_up ? SERVE_UP : SERVE_DOWN;
        end
        SERVE_UP: begin
          if (arrive)
            state_n = DOOR;
          else if (!up_found)
            state_n = below ? SERVE_DOWN : IDLE;
        end
        SERVE_DOWN: begin
          if (arrive)
            state_n = DOOR;
          else if (!dn_found)
            state_n = above ? SERVE_UP : IDLE;
        end
        DOOR: begin
          // A fresh press at this floor keeps the door open.
          if (call_here) begin
            cnt_n = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (dir_up)
              state_n = above ? SERVE_UP :
                        below ? SERVE_DOWN : IDLE;
            else
              state_n = below ? SERVE_DOWN :
                        above ? SERVE_UP : IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    entry = (state_n == DOOR) && (state != DOOR);
    if (entry)
      cnt_n = '0;
  end

  assign absorb    = (state == DOOR) ? cur_hot : '0;
  assign clr       = entry ? cur_hot : '0;
  assign pending_n = (pending | (call_req & ~absorb)) & ~clr;

  always_comb begin
    tf_n  = target_floor;
    tv_n  = 1'b0;
    dir_n = dir_up;
    unique case (1'b1)
      (state_n == SERVE_UP): begin
        tf_n  = up_floor;
        tv_n  = 1'b1;
        dir_n = 1'b1;
      end
      (state_n == SERVE_DOWN): begin
        tf_n  = dn_floor;
        tv_n  = 1'b1;
        dir_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      door_open    <= 1'b0;
      dir_up       <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pending      <= pending_n;
      target_floor <= tf_n;
      target_valid <= tv_n;
      door_open    <= (state_n == DOOR);
      dir_up       <= dir_n;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: SCAN ordering,
// door timing, absorption, reset and out-of-range floor.
module tb_elevator_call_scheduler;

  localparam int NF = 10;
  localparam int FW = 4;

  logic          clk;
  logic          reset;
  logic [NF-1:0] call_req;
  logic [FW-1:0] current_floor;
  logic          car_idle;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          door_open;
  logic          dir_up;
  logic [NF-1:0] pending;

  int compared   = 0;
  int mismatched = 0;
  int n;

  elevator_call_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .DOOR_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_req     (call_req),
    .current_floor(current_floor),
    .car_idle     (car_idle),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .door_open    (door_open),
    .dir_up       (dir_up),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_close(output int cycles);
    cycles = 0;
    while (door_open === 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    call_req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    call_req      = '0;
    current_floor = 4'd0;
    car_idle      = 1'b1;
    #1;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_tv", 32'(target_valid), 0);
    chk("rst_tf", 32'(target_floor), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_dir", 32'(dir_up), 1);

    // Basic call to floor 3 from floor 0
    do_reset();
    call_req = 10'h008;
    tick();
    call_req = '0;
    chk("s1_pending", 32'(pending), 32'h008);
    chk("s1_tv0", 32'(target_valid), 0);
    tick();
    chk("s1_tv", 32'(target_valid), 1);
    chk("s1_tf", 32'(target_floor), 3);
    chk("s1_dir", 32'(dir_up), 1);
    chk("s1_door", 32'(door_open), 0);
    current_floor = 4'd3;
    tick();
    chk("s1_door_open", 32'(door_open), 1);
    chk("s1_clr", 32'(pending), 0);
    wait_close(n);
    chk("s1_door_len", 32'(n), 16);
    chk("s1_idle_tv", 32'(target_valid), 0);

    // Retarget mid-travel: stops 4, 5, 7
    current_floor = 4'd2;
    do_reset();
    call_req = 10'h0A0;
    tick();
    call_req = '0;
    tick();
    chk("s2_tf5", 32'(target_floor), 5);
    chk("s2_tv", 32'(target_valid), 1);
    car_idle      = 1'b0;
    current_floor = 4'd3;
    call_req      = 10'h010;
    tick();
    call_req = '0;
    chk("s2_pend3", 32'(pending), 32'h0B0);
    chk("s2_tf_old", 32'(target_floor), 5);
    tick();
    chk("s2_tf4", 32'(target_floor), 4);
    current_floor = 4'd4;
    car_idle      = 1'b1;
    tick();
    chk("s2_door4", 32'(door_open), 1);
    chk("s2_clr4", 32'(pending), 32'h0A0);
    chk("s2_tv_door", 32'(target_valid), 0);
    wait_close(n);
    chk("s2_len4", 32'(n), 16);
    chk("s2_tf5b", 32'(target_floor), 5);
    chk("s2_tv5", 32'(target_valid), 1);
    current_floor = 4'd5;
    tick();
    chk("s2_door5", 32'(door_open), 1);
    chk("s2_clr5", 32'(pending), 32'h080);
    wait_close(n);
    chk("s2_len5", 32'(n), 16);
    chk("s2_tf7", 32'(target_floor), 7);
    current_floor = 4'd7;
    tick();
    chk("s2_door7", 32'(door_open), 1);
    chk("s2_clr7", 32'(pending), 0);
    wait_close(n);
    chk("s2_len7", 32'(n), 16);
    chk("s2_end_tv", 32'(target_valid), 0);

    // Distance tie from floor 5 with calls at 2 and 8
    current_floor = 4'd5;
    do_reset();
    call_req = 10'h104;
    tick();
    call_req = '0;
    chk("s3_pend", 32'(pending), 32'h104);
    tick();
    chk("s3_tf8", 32'(target_floor), 8);
    chk("s3_dir_up", 32'(dir_up), 1);
    current_floor = 4'd8;
    tick();
    chk("s3_door8", 32'(door_open), 1);
    chk("s3_clr8", 32'(pending), 32'h004);
    wait_close(n);
    chk("s3_len8", 32'(n), 16);
    chk("s3_tf2", 32'(target_floor), 2);
    chk("s3_dir_dn", 32'(dir_up), 0);
    chk("s3_tv2", 32'(target_valid), 1);
    current_floor = 4'd2;
    tick();
    chk("s3_door2", 32'(door_open), 1);
    wait_close(n);
    chk("s3_len2", 32'(n), 16);

    // Re-press at the open floor restarts the door timer
    current_floor = 4'd4;
    do_reset();
    call_req = 10'h010;
    tick();
    call_req = '0;
    tick();
    chk("s4_door", 32'(door_open), 1);
    for (int i = 0; i < 10; i++) tick();
    call_req = 10'h010;
    tick();
    call_req = '0;
    chk("s4_absorb", 32'(pending), 0);
    chk("s4_door_held", 32'(door_open), 1);
    wait_close(n);
    chk("s4_len", 32'(n), 16);

    // Call at the current floor while idle
    current_floor = 4'd6;
    do_reset();
    call_req = 10'h040;
    tick();
    call_req = '0;
    chk("s5_pend", 32'(pending), 32'h040);
    chk("s5_tv_a", 32'(target_valid), 0);
    tick();
    chk("s5_door", 32'(door_open), 1);
    chk("s5_tv_b", 32'(target_valid), 0);
    chk("s5_clr", 32'(pending), 0);
    wait_close(n);
    chk("s5_len", 32'(n), 16);

    // Asynchronous reset mid-travel
    current_floor = 4'd5;
    do_reset();
    call_req = 10'h202;
    tick();
    call_req = '0;
    tick();
    chk("s6_tf9", 32'(target_floor), 9);
    car_idle      = 1'b0;
    current_floor = 4'd6;
    tick();
    chk("s6_tv_pre", 32'(target_valid), 1);
    reset = 1'b1;
    #2;
    chk("s6_arst_pend", 32'(pending), 0);
    chk("s6_arst_tv", 32'(target_valid), 0);
    chk("s6_arst_tf", 32'(target_floor), 0);
    chk("s6_arst_dir", 32'(dir_up), 1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("s6_post_tv", 32'(target_valid), 0);
    chk("s6_post_pend", 32'(pending), 0);

    // Out-of-range current_floor
    car_idle      = 1'b1;
    current_floor = 4'd5;
    call_req      = 10'h202;
    tick();
    call_req = '0;
    tick();
    chk("s7_tv_pre", 32'(target_valid), 1);
    current_floor = 4'd12;
    call_req      = 10'h008;
    tick();
    call_req = '0;
    chk("s7_fault_tv", 32'(target_valid), 0);
    chk("s7_fault_pend", 32'(pending), 32'h20A);
    current_floor = 4'd5;
    tick();
    chk("s7_resume_tv", 32'(target_valid), 1);
    chk("s7_resume_tf", 32'(target_floor), 3);
    chk("s7_resume_dir", 32'(dir_up), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
